clk_step_ctrl: RTL and testbench

// Run/stop/single-step controller driving the clken input of the CPU clock divider.

---
 rtl/clk_step_ctrl.sv | 121 ++++++++++++
 tb/tb_clk_step_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clk_step_ctrl.sv
// Run/stop/single-step controller gating the CPU clock divider through clken.
// Debounces the run and step buttons, latches CPU halt, counts enabled clk_slow rises.
module clk_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             halt_req,
    input  logic             clk_slow,
    output logic             clken,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LIMIT = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_STEP,
        ST_HALTED
    } state_t;

    state_t state, state_next;

    // Index 0 = run button, index 1 = step button.
    logic [1:0]    sync1, sync2, deb, press;
    logic [DW-1:0] db_cnt [2];

    logic clk_slow_q, clken_q, rise;
    logic run_press, step_press;

    // Counter measures how long the synced level has disagreed with the accepted one.
    always_ff @(posedge clkin) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            press  <= '0;
            db_cnt <= '{default: '0};
        end else begin
            sync1 <= {btn_step, btn_run};
            sync2 <= sync1;
            press <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LIMIT) begin
                    db_cnt[i] <= '0;
                    deb[i]    <= sync2[i];
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign run_press  = press[0];
    assign step_press = press[1];

    always_ff @(posedge clkin) begin
        if (rst) begin
            clk_slow_q <= 1'b0;
            clken_q    <= 1'b0;
            step_count <= '0;
            state      <= ST_STOP;
        end else begin
            clk_slow_q <= clk_slow;
            clken_q    <= clken;
            state      <= state_next;
            if (rise && clken_q)
                step_count <= step_count + CNT_W'(1);
        end
    end

    assign rise = clk_slow & ~clk_slow_q;

    // clken drops in the rise cycle so a step freezes the divider with clk_slow high.
    always_comb begin
        state_next = state;
        clken      = 1'b0;
        case (state)
            ST_STOP: begin
                if (run_press)
                    state_next = ST_RUN;
                else if (step_press)
                    state_next = ST_STEP;
            end
            ST_RUN: begin
                clken = 1'b1;
                if (halt_req)
                    state_next = ST_HALTED;
                else if (run_press)
                    state_next = ST_STOP;
            end
            ST_STEP: begin
                clken = ~rise;
                if (halt_req)
                    state_next = ST_HALTED;
                else if (rise)
                    state_next = ST_STOP;
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_STOP;
            end
        endcase
    end

    assign running = (state == ST_RUN);
    assign halted  = (state == ST_HALTED);

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Scoreboard bench for clk_step_ctrl with a countlimit=3 divider closing the loop.
// Expected outputs are hand-computed per clkin edge and checked by a negedge monitor.
module tb_clk_step_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clkin = 1'b0;
    logic             rst, btn_run, btn_step, halt_req;
    logic             clk_slow, clken, running, halted;
    logic [CNT_W-1:0] step_count;
    logic [1:0]       div_cnt;

    typedef struct {
        string            name;
        logic             ce;
        logic             run;
        logic             hlt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    clk_step_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clkin      (clkin),
        .rst        (rst),
        .btn_run    (btn_run),
        .btn_step   (btn_step),
        .halt_req   (halt_req),
        .clk_slow   (clk_slow),
        .clken      (clken),
        .running    (running),
        .halted     (halted),
        .step_count (step_count)
    );

    always #5 clkin = ~clkin;

    // Divider: toggles clk_slow every third enabled cycle.
    always @(posedge clkin) begin
        if (rst) begin
            div_cnt  <= 2'd0;
            clk_slow <= 1'b0;
        end else if (clken) begin
            if (div_cnt == 2'd2) begin
                div_cnt  <= 2'd0;
                clk_slow <= ~clk_slow;
            end else begin
                div_cnt <= div_cnt + 2'd1;
            end
        end
    end

    task automatic cmp(input string nm, input string fld, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", nm, fld, act, exp, $time);
        end
    endtask

    always @(negedge clkin) begin
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            cmp(e.name, "clken", CNT_W'(clken), CNT_W'(e.ce));
            cmp(e.name, "running", CNT_W'(running), CNT_W'(e.run));
            cmp(e.name, "halted", CNT_W'(halted), CNT_W'(e.hlt));
            cmp(e.name, "step_count", step_count, e.cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string nm, input logic ce, input logic run, input logic hlt,
                       input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.name = nm; e.ce = ce; e.run = run; e.hlt = hlt; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic reset_dut();
        rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; halt_req = 1'b0;
        tick(2);
        chk("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with bouncing buttons
        rst = 1'b1; halt_req = 1'b0; btn_run = 1'b1; btn_step = 1'b0;
        tick(1); chk("rst_c1", 1'b0, 1'b0, 1'b0, 8'd0);
        btn_run = 1'b0; btn_step = 1'b1;
        tick(1); chk("rst_c2", 1'b0, 1'b0, 1'b0, 8'd0);
        btn_run = 1'b1; btn_step = 1'b0;
        tick(1); chk("rst_c3", 1'b0, 1'b0, 1'b0, 8'd0);

        // 2: bouncy run press, then free-run
        rst = 1'b0; btn_run = 1'b1; btn_step = 1'b0;
        tick(1); btn_run = 1'b0;
        tick(1); btn_run = 1'b1;
        tick(6); chk("bounce_wait", 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1); chk("run_enter", 1'b1, 1'b1, 1'b0, 8'd0);
        tick(3); chk("run_rise0", 1'b1, 1'b1, 1'b0, 8'd0);
        btn_run = 1'b0;
        tick(1); chk("run_cnt1", 1'b1, 1'b1, 1'b0, 8'd1);
        tick(6); chk("run_cnt2", 1'b1, 1'b1, 1'b0, 8'd2);
        tick(6); chk("run_cnt3", 1'b1, 1'b1, 1'b0, 8'd3);

        // 3: two single steps
        reset_dut();
        btn_step = 1'b1;
        tick(7); chk("step1_enter", 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1); btn_step = 1'b0;
        tick(1); chk("step1_wait", 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1); chk("step1_rise", 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1); chk("step1_done", 1'b0, 1'b0, 1'b0, 8'd1);
        tick(9); chk("step1_idle", 1'b0, 1'b0, 1'b0, 8'd1);
        btn_step = 1'b1;
        tick(7); chk("step2_enter", 1'b1, 1'b0, 1'b0, 8'd1);
        tick(1); btn_step = 1'b0;
        tick(4); chk("step2_wait", 1'b1, 1'b0, 1'b0, 8'd1);
        tick(1); chk("step2_rise", 1'b0, 1'b0, 1'b0, 8'd1);
        tick(1); chk("step2_done", 1'b0, 1'b0, 1'b0, 8'd2);
        tick(6); chk("step2_idle", 1'b0, 1'b0, 1'b0, 8'd2);

        // 4: halt wins over a simultaneous run press; HALTED is sticky
        reset_dut();
        btn_run = 1'b1;
        tick(7); chk("h_run", 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1); btn_run = 1'b0;
        tick(3); chk("h_cnt1", 1'b1, 1'b1, 1'b0, 8'd1);
        tick(9); btn_run = 1'b1;
        tick(6); chk("h_pre", 1'b1, 1'b1, 1'b0, 8'd3);
        halt_req = 1'b1;
        tick(1); chk("h_enter", 1'b0, 1'b0, 1'b1, 8'd3);
        halt_req = 1'b0;
        tick(1); btn_run = 1'b0;
        tick(10); btn_run = 1'b1; btn_step = 1'b1;
        tick(8); btn_run = 1'b0; btn_step = 1'b0;
        tick(12); chk("h_sticky", 1'b0, 1'b0, 1'b1, 8'd3);

        // 5: run and step together -> run wins; second run press stops
        reset_dut();
        btn_run = 1'b1; btn_step = 1'b1;
        tick(7); chk("both_run", 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1); btn_run = 1'b0; btn_step = 1'b0;
        tick(4); chk("both_cnt1", 1'b1, 1'b1, 1'b0, 8'd1);
        tick(8); btn_run = 1'b1;
        tick(6); chk("stop_pre", 1'b1, 1'b1, 1'b0, 8'd3);
        tick(1); chk("stop_enter", 1'b0, 1'b0, 1'b0, 8'd3);
        tick(1); chk("stop_hold", 1'b0, 1'b0, 1'b0, 8'd3);
        btn_run = 1'b0;
        tick(7); chk("stop_idle", 1'b0, 1'b0, 1'b0, 8'd3);

        // 6: wrap of step_count, then reset in the middle of a step
        reset_dut();
        btn_run = 1'b1;
        tick(8); btn_run = 1'b0;
        tick(1527); chk("wrap_max", 1'b1, 1'b1, 1'b0, 8'd255);
        tick(6); chk("wrap_zero", 1'b1, 1'b1, 1'b0, 8'd0);
        tick(4); btn_run = 1'b1;
        tick(6); chk("wrap_cnt1", 1'b1, 1'b1, 1'b0, 8'd1);
        tick(1); chk("wrap_stop", 1'b0, 1'b0, 1'b0, 8'd1);
        tick(1); chk("wrap_lastrise", 1'b0, 1'b0, 1'b0, 8'd2);
        btn_run = 1'b0;
        tick(7); chk("wrap_idle", 1'b0, 1'b0, 1'b0, 8'd2);
        btn_step = 1'b1;
        tick(7); chk("rs_step", 1'b1, 1'b0, 1'b0, 8'd2);
        tick(2); chk("rs_mid", 1'b1, 1'b0, 1'b0, 8'd2);
        rst = 1'b1; btn_step = 1'b0;
        tick(1); chk("rs_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        tick(1); chk("rs_after", 1'b0, 1'b0, 1'b0, 8'd0);
        tick(8); chk("rs_idle", 1'b0, 1'b0, 1'b0, 8'd0);

        tick(2);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
